// File: rtl/nvme_sched_pkg.sv
// Shared types, widths and helpers for the NVMe submission-queue fetch scheduler.
// Optional build macro used by the scheduler: NVME_SQ_ADMIN_PRIO_EN.
package nvme_sched_pkg;

   localparam int unsigned C_SQ_NUM_DFLT = 9;
   localparam int unsigned C_QID_W       = 4;
   localparam int unsigned C_PTR_W       = 8;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } sched_state_e;

   typedef struct packed {
      logic [C_QID_W-1:0] qid;
      logic [C_PTR_W-1:0] slot;
   } fetch_cmd_t;

   // Circular queue index advance: the last entry (zero-based size) wraps to 0.
   function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] ptr,
                                                  input logic [C_PTR_W-1:0] size);
      return (ptr == size) ? '0 : C_PTR_W'(ptr + 1'b1);
   endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Combinational rotating-priority picker: first request at or above rr_ptr, wrapping.
module nvme_rr_arbiter #(
   parameter int unsigned C_N     = 9,
   parameter int unsigned C_IDX_W = 4
) (
   input  logic [C_N-1:0]     req_i,
   input  logic [C_IDX_W-1:0] rr_ptr_i,
   output logic [C_IDX_W-1:0] grant_c_o,
   output logic               any_c_o
);

   logic               hi_hit;
   logic               lo_hit;
   logic [C_IDX_W-1:0] hi_idx;
   logic [C_IDX_W-1:0] lo_idx;

   // Descending scan so the lowest index in each half is the one that sticks.
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = int'(C_N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            if (i >= int'(rr_ptr_i)) begin
               hi_hit = 1'b1;
               hi_idx = C_IDX_W'(i);
            end else begin
               lo_hit = 1'b1;
               lo_idx = C_IDX_W'(i);
            end
         end
      end
      any_c_o   = hi_hit | lo_hit;
      grant_c_o = hi_hit ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/nvme_sq_fetch_sched.sv
// Round-robin SQ command-fetch scheduler with outstanding-fetch credit limit.
// Define NVME_SQ_ADMIN_PRIO_EN to give the admin queue (0) strict priority.
module nvme_sq_fetch_sched
   import nvme_sched_pkg::*;
#(
   parameter int unsigned C_SQ_NUM          = C_SQ_NUM_DFLT,
   parameter int unsigned C_PTR_WIDTH       = C_PTR_W,
   parameter int unsigned C_MAX_OUTSTANDING = 4
) (
   input  logic                            pcie_user_clk,
   input  logic                            pcie_user_rst_n,
   input  logic [C_SQ_NUM*C_PTR_WIDTH-1:0] sq_tail_ptr,
   input  logic [C_SQ_NUM*C_PTR_WIDTH-1:0] sq_size,
   input  logic [C_SQ_NUM-1:0]             sq_valid,
   input  logic [C_SQ_NUM-1:0]             sq_rst_n,
   output logic                            fetch_req,
   output logic [C_QID_W-1:0]              fetch_qid,
   output logic [C_PTR_WIDTH-1:0]          fetch_slot,
   input  logic                            fetch_ack,
   input  logic                            fetch_done,
   output logic [C_SQ_NUM*C_PTR_WIDTH-1:0] sq_head_ptr,
   output logic                            sched_busy
);

   localparam int unsigned C_OUT_W = $clog2(C_MAX_OUTSTANDING + 1);

   sched_state_e            state_q, state_d;
   fetch_cmd_t              cmd_q, cmd_d;
   logic                    req_q, req_d;
   logic                    busy_q, busy_d;
   logic                    rst_seen_q, rst_seen_d;
   logic [C_QID_W-1:0]      rr_q, rr_d;
   logic [C_OUT_W-1:0]      out_q, out_d;
   logic [C_PTR_WIDTH-1:0]  head_q [C_SQ_NUM];
   logic [C_PTR_WIDTH-1:0]  head_d [C_SQ_NUM];
   logic [C_PTR_WIDTH-1:0]  tail_c [C_SQ_NUM];
   logic [C_PTR_WIDTH-1:0]  size_c [C_SQ_NUM];
   logic [C_SQ_NUM-1:0]     pending_c;
   logic [C_QID_W-1:0]      arb_grant_c;
   logic [C_QID_W-1:0]      pick_c;
   logic [C_QID_W-1:0]      rr_nxt_c;
   logic                    arb_any_c;
   logic                    credit_ok_c;
   logic                    ack_take_c;
   logic                    done_take_c;

   for (genvar g = 0; g < C_SQ_NUM; g++) begin : g_q
      assign tail_c[g]    = sq_tail_ptr[g*C_PTR_WIDTH +: C_PTR_WIDTH];
      assign size_c[g]    = sq_size[g*C_PTR_WIDTH +: C_PTR_WIDTH];
      assign pending_c[g] = sq_valid[g] & sq_rst_n[g] & (tail_c[g] != head_q[g]);
      assign sq_head_ptr[g*C_PTR_WIDTH +: C_PTR_WIDTH] = head_q[g];
   end

   nvme_rr_arbiter #(
      .C_N     (C_SQ_NUM),
      .C_IDX_W (C_QID_W)
   ) u_arb (
      .req_i     (pending_c),
      .rr_ptr_i  (rr_q),
      .grant_c_o (arb_grant_c),
      .any_c_o   (arb_any_c)
   );

`ifdef NVME_SQ_ADMIN_PRIO_EN
   assign pick_c = pending_c[0] ? '0 : arb_grant_c;
`else
   assign pick_c = arb_grant_c;
`endif

   assign credit_ok_c = (out_q < C_OUT_W'(C_MAX_OUTSTANDING));
   assign ack_take_c  = (state_q == S_REQ) & fetch_ack;
   assign done_take_c = fetch_done & (out_q != '0);
   assign rr_nxt_c    = (cmd_q.qid == C_QID_W'(C_SQ_NUM - 1)) ? '0 : C_QID_W'(cmd_q.qid + 1'b1);

   // Next-state, head, credit and round-robin pointer logic.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      req_d      = req_q;
      rst_seen_d = rst_seen_q;
      rr_d       = rr_q;
      out_d      = out_q;
      head_d     = head_q;

      case (state_q)
         S_IDLE: begin
            if (arb_any_c && credit_ok_c) begin
               state_d    = S_REQ;
               req_d      = 1'b1;
               cmd_d.qid  = pick_c;
               cmd_d.slot = C_PTR_W'(head_q[pick_c]);
               rst_seen_d = 1'b0;
            end
         end
         S_REQ: begin
            if (!sq_rst_n[cmd_q.qid]) begin
               rst_seen_d = 1'b1;
            end
            if (fetch_ack) begin
               state_d    = S_IDLE;
               req_d      = 1'b0;
               rst_seen_d = 1'b0;
               // A queue reset seen during the request keeps the head parked at 0.
               if (!rst_seen_q && sq_rst_n[cmd_q.qid]) begin
                  head_d[cmd_q.qid] = C_PTR_WIDTH'(ptr_inc(C_PTR_W'(head_q[cmd_q.qid]),
                                                           C_PTR_W'(size_c[cmd_q.qid])));
               end
`ifdef NVME_SQ_ADMIN_PRIO_EN
               if (cmd_q.qid != '0) begin
                  rr_d = rr_nxt_c;
               end
`else
               rr_d = rr_nxt_c;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase

      case ({ack_take_c, done_take_c})
         2'b10:   out_d = C_OUT_W'(out_q + 1'b1);
         2'b01:   out_d = C_OUT_W'(out_q - 1'b1);
         default: out_d = out_q;
      endcase

      for (int i = 0; i < int'(C_SQ_NUM); i++) begin
         if (!sq_rst_n[i]) begin
            head_d[i] = '0;
         end
      end

      busy_d = (state_d != S_IDLE) || (out_d != '0);
   end

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         rst_seen_q <= 1'b0;
         rr_q       <= '0;
         out_q      <= '0;
         for (int i = 0; i < int'(C_SQ_NUM); i++) begin
            head_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         rst_seen_q <= rst_seen_d;
         rr_q       <= rr_d;
         out_q      <= out_d;
         for (int i = 0; i < int'(C_SQ_NUM); i++) begin
            head_q[i] <= head_d[i];
         end
      end
   end

   assign fetch_req  = req_q;
   assign fetch_qid  = cmd_q.qid;
   assign fetch_slot = C_PTR_WIDTH'(cmd_q.slot);
   assign sched_busy = busy_q;

`ifndef SYNTHESIS
   a_done_underflow: assert property (@(posedge pcie_user_clk) disable iff (!pcie_user_rst_n)
      fetch_done |-> (out_q != '0));
`endif

endmodule

// File: tb/tb_nvme_sq_fetch_sched.sv
// Randomized and directed bench for nvme_sq_fetch_sched against a queue-level reference model.
module tb_nvme_sq_fetch_sched;

   localparam int unsigned N    = 9;
   localparam int unsigned PW   = 8;
   localparam int unsigned MAXO = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*PW-1:0] sq_tail_ptr;
   logic [N*PW-1:0] sq_size;
   logic [N*PW-1:0] sq_head_ptr;
   logic [N-1:0]    sq_valid;
   logic [N-1:0]    sq_rst_n;
   logic            fetch_req;
   logic [3:0]      fetch_qid;
   logic [PW-1:0]   fetch_slot;
   logic            fetch_ack;
   logic            fetch_done;
   logic            sched_busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [PW-1:0] m_head [N];
   int            m_out;
   int            m_rr;
   bit            m_req;
   bit            m_rst_seen;
   int            m_qid;
   logic [PW-1:0] m_slot;
   int            grant_q [$];
   int            slot_q  [$];

   always #5 clk = ~clk;

   nvme_sq_fetch_sched #(
      .C_SQ_NUM          (N),
      .C_PTR_WIDTH       (PW),
      .C_MAX_OUTSTANDING (MAXO)
   ) dut (
      .pcie_user_clk   (clk),
      .pcie_user_rst_n (rst_n),
      .sq_tail_ptr     (sq_tail_ptr),
      .sq_size         (sq_size),
      .sq_valid        (sq_valid),
      .sq_rst_n        (sq_rst_n),
      .fetch_req       (fetch_req),
      .fetch_qid       (fetch_qid),
      .fetch_slot      (fetch_slot),
      .fetch_ack       (fetch_ack),
      .fetch_done      (fetch_done),
      .sq_head_ptr     (sq_head_ptr),
      .sched_busy      (sched_busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [PW-1:0] tail_of(input int q);
      return sq_tail_ptr[q*PW +: PW];
   endfunction

   function automatic logic [PW-1:0] size_of(input int q);
      return sq_size[q*PW +: PW];
   endfunction

   function automatic bit pend(input int q);
      return sq_valid[q] && sq_rst_n[q] && (tail_of(q) != m_head[q]);
   endfunction

   function automatic int winner();
`ifdef NVME_SQ_ADMIN_PRIO_EN
      if (pend(0)) return 0;
`endif
      for (int k = 0; k < int'(N); k++) begin
         if (pend((m_rr + k) % int'(N))) return (m_rr + k) % int'(N);
      end
      return -1;
   endfunction

   function automatic logic [N*PW-1:0] model_heads();
      logic [N*PW-1:0] v;
      for (int i = 0; i < int'(N); i++) v[i*PW +: PW] = m_head[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(N); i++) m_head[i] = '0;
      m_out = 0; m_rr = 0; m_req = 0; m_rst_seen = 0; m_qid = 0; m_slot = '0;
   endtask

   task automatic set_q(input int q, input bit v, input int size, input int tail);
      sq_valid[q]           = v;
      sq_size[q*PW +: PW]   = PW'(size);
      sq_tail_ptr[q*PW +: PW] = PW'(tail);
   endtask

   // One clock: drive ack/done, advance the model through the edge, then compare.
   task automatic tick(input bit ack, input bit done);
      int w;
      bit nreq;
      fetch_ack  = ack && m_req;
      fetch_done = done && (m_out > 0);
      if (fetch_ack) begin
         grant_q.push_back(int'(fetch_qid));
         slot_q.push_back(int'(fetch_slot));
      end
      nreq = m_req;
      if (m_req) begin
         if (!sq_rst_n[m_qid]) m_rst_seen = 1;
         if (fetch_ack) begin
            if (!m_rst_seen)
               m_head[m_qid] = (m_head[m_qid] == size_of(m_qid)) ? '0 : PW'(m_head[m_qid] + 1);
            m_out++;
`ifdef NVME_SQ_ADMIN_PRIO_EN
            if (m_qid != 0) m_rr = (m_qid + 1) % int'(N);
`else
            m_rr = (m_qid + 1) % int'(N);
`endif
            nreq = 0;
         end
      end else begin
         w = winner();
         if (w >= 0 && m_out < int'(MAXO)) begin
            nreq = 1; m_qid = w; m_slot = m_head[w]; m_rst_seen = 0;
         end
      end
      if (fetch_done) m_out--;
      for (int i = 0; i < int'(N); i++) if (!sq_rst_n[i]) m_head[i] = '0;
      m_req = nreq;
      @(negedge clk);
      fetch_ack  = 1'b0;
      fetch_done = 1'b0;
      check("req", 128'(fetch_req), 128'(m_req));
      if (m_req) begin
         check("qid", 128'(fetch_qid), 128'(m_qid));
         check("slot", 128'(fetch_slot), 128'(m_slot));
      end
      check("heads", 128'(sq_head_ptr), 128'(model_heads()));
      check("busy", 128'(sched_busy), 128'(m_req || (m_out > 0)));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; fetch_ack = 1'b0; fetch_done = 1'b0;
      sq_tail_ptr = '0; sq_size = '0; sq_valid = '0; sq_rst_n = '1;
      model_reset();
      grant_q.delete(); slot_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic expect_grant(input string tag, input int idx, input int q, input int s);
      check({tag, "_qid"},  128'(idx < grant_q.size() ? grant_q[idx] : -1), 128'(q));
      check({tag, "_slot"}, 128'(idx < slot_q.size()  ? slot_q[idx]  : -1), 128'(s));
   endtask

   initial begin
      int nd;
      int q;
      do_reset();
      check("rst_req",   128'(fetch_req),   128'(0));
      check("rst_qid",   128'(fetch_qid),   128'(0));
      check("rst_slot",  128'(fetch_slot),  128'(0));
      check("rst_heads", 128'(sq_head_ptr), 128'(0));
      check("rst_busy",  128'(sched_busy),  128'(0));

      // Admin queue: two entries fetched back to back.
      set_q(0, 1, 3, 2);
      repeat (8) tick(1, 0);
      check("t1_count", 128'(grant_q.size()), 128'(2));
      expect_grant("t1_g0", 0, 0, 0);
      expect_grant("t1_g1", 1, 0, 1);
      check("t1_head0", 128'(sq_head_ptr[7:0]), 128'(2));
      tick(0, 1);
      check("t1_busy_after1", 128'(sched_busy), 128'(1));
      tick(0, 1);
      check("t1_busy_after2", 128'(sched_busy), 128'(0));

      // Round-robin order across 1, 3, 5.
      do_reset();
      set_q(1, 1, 7, 2); set_q(3, 1, 7, 2); set_q(5, 1, 7, 2);
      repeat (14) tick(1, 0);
      expect_grant("t2_g0", 0, 1, 0);
      expect_grant("t2_g1", 1, 3, 0);
      expect_grant("t2_g2", 2, 5, 0);
      expect_grant("t2_g3", 3, 1, 1);
      repeat (12) tick(1, 1);

      // Head wrap: slots 3 then 0.
      do_reset();
      set_q(2, 1, 3, 3);
      repeat (10) tick(1, 1);
      grant_q.delete(); slot_q.delete();
      sq_tail_ptr[2*PW +: PW] = 8'd1;
      repeat (10) tick(1, 1);
      check("t3_count", 128'(grant_q.size()), 128'(2));
      expect_grant("t3_g0", 0, 2, 3);
      expect_grant("t3_g1", 1, 2, 0);
      check("t3_head2", 128'(sq_head_ptr[2*PW +: PW]), 128'(1));

      // Credit limit, release by one done, and simultaneous ack+done.
      do_reset();
      set_q(1, 1, 15, 6);
      repeat (20) tick(1, 0);
      check("t4_capped", 128'(grant_q.size()), 128'(4));
      check("t4_head1", 128'(sq_head_ptr[PW +: PW]), 128'(4));
      tick(0, 1);
      repeat (3) tick(1, 0);
      check("t4_fifth", 128'(grant_q.size()), 128'(5));
      tick(0, 1);
      tick(0, 0);
      tick(1, 1);
      check("t4_sixth", 128'(grant_q.size()), 128'(6));
      nd = 0;
      for (int k = 0; k < 6 && sched_busy; k++) begin
         tick(0, 1);
         nd++;
      end
      check("t4_dones_to_idle", 128'(nd), 128'(3));

      // Queue reset in the middle of an active request.
      do_reset();
      set_q(4, 1, 7, 3);
      repeat (3) tick(0, 0);
      sq_rst_n[4] = 1'b0;
      tick(0, 0);
      sq_rst_n[4] = 1'b1;
      tick(0, 0);
      tick(1, 0);
      check("t5_head4", 128'(sq_head_ptr[4*PW +: PW]), 128'(0));
      check("t5_busy", 128'(sched_busy), 128'(1));
      check("t5_slot", 128'(slot_q.size() > 0 ? slot_q[0] : -1), 128'(0));
      repeat (4) tick(0, 0);

      // Admin versus I/O with rr_ptr parked at 6.
      do_reset();
      set_q(5, 1, 7, 1);
      repeat (4) tick(1, 1);
      grant_q.delete(); slot_q.delete();
      set_q(0, 1, 7, 1); set_q(6, 1, 7, 1);
      repeat (6) tick(1, 1);
`ifdef NVME_SQ_ADMIN_PRIO_EN
      expect_grant("t6_g0", 0, 0, 0);
      expect_grant("t6_g1", 1, 6, 0);
`else
      expect_grant("t6_g0", 0, 6, 0);
      expect_grant("t6_g1", 1, 0, 0);
`endif

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < int'(N); i++) begin
         sq_size[i*PW +: PW] = PW'($urandom_range(15, 1));
         sq_valid[i] = ($urandom_range(3, 0) != 0);
      end
      for (int t = 0; t < 800; t++) begin
         q = int'($urandom_range(N - 1, 0));
         if ($urandom_range(2, 0) == 0)
            sq_tail_ptr[q*PW +: PW] = (tail_of(q) == size_of(q)) ? '0 : PW'(tail_of(q) + 1);
         if ($urandom_range(29, 0) == 0) sq_valid[q] = ~sq_valid[q];
         sq_rst_n = '1;
         if ($urandom_range(59, 0) == 0) sq_rst_n[$urandom_range(N - 1, 0)] = 1'b0;
         tick($urandom_range(9, 0) < 7, $urandom_range(1, 0) == 1);
      end
      sq_rst_n = '1;

      // Asynchronous reset while a request is held.
      do_reset();
      set_q(3, 1, 7, 2);
      repeat (2) tick(0, 0);
      check("t8_req_before", 128'(fetch_req), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("t8_req_dropped", 128'(fetch_req), 128'(0));
      check("t8_heads", 128'(sq_head_ptr), 128'(0));
      check("t8_busy", 128'(sched_busy), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nvme_sq_fetch_sched.md
Name: nvme_sq_fetch_sched

Overview:
- Round-robin scheduler that decides which NVMe submission queue (admin SQ0 plus I/O SQ1..8) has its next command entry fetched from host memory.
- Compares each queue's doorbell tail pointer with a locally held head pointer, issues one fetch request at a time to the host-read DMA engine, and advances the head on acceptance.
- Caps outstanding fetches with a credit counter.
- Sits between the controller register block (tail pointers, queue sizes, queue resets) and the command-fetch DMA path, all in the PCIe user clock domain.

Parameters:
- C_SQ_NUM, 9, number of submission queues; index 0 is the admin SQ.
- C_PTR_WIDTH, 8, width of the head, tail and size fields.
- C_MAX_OUTSTANDING, 4, maximum accepted-but-not-completed fetches (1..7).

Ports:
- pcie_user_clk  in  1  clock.
- pcie_user_rst_n  in  1  asynchronous active-low reset.
- sq_tail_ptr  in  C_SQ_NUM*C_PTR_WIDTH  packed doorbell tail pointers; queue i is in bits [i*8+7:i*8].
- sq_size  in  C_SQ_NUM*C_PTR_WIDTH  zero-based queue sizes (entries-1), same packing.
- sq_valid  in  C_SQ_NUM  queue created and enabled.
- sq_rst_n  in  C_SQ_NUM  per-queue synchronous clear, active-low.
- fetch_req  out  1  fetch request valid.
- fetch_qid  out  4  queue id of the request.
- fetch_slot  out  C_PTR_WIDTH  entry index to fetch (head value).
- fetch_ack  in  1  DMA accepts the request.
- fetch_done  in  1  one previously accepted fetch has completed.
- sq_head_ptr  out  C_SQ_NUM*C_PTR_WIDTH  current head pointers, used for the CQE SQHD field.
- sched_busy  out  1  high when state is not IDLE or outstanding>0.

Behaviour:
- Reset values: all outputs 0; heads 0; rr_ptr 0; outstanding 0; state S_IDLE.
- pending[i] = sq_valid[i] & sq_rst_n[i] & (tail[i] != head[i]).
- Credit check: credit_ok = (outstanding < C_MAX_OUTSTANDING).
- FSM states: S_IDLE, S_REQ.
- S_IDLE, when any pending and credit_ok:
  - Pick the first pending queue at or above rr_ptr, wrapping modulo C_SQ_NUM.
  - Latch fetch_qid and fetch_slot = head[winner].
  - Go to S_REQ. fetch_req rises the cycle after the decision (1-cycle latency).
- S_REQ:
  - fetch_req stays high and fetch_qid/fetch_slot stay stable until fetch_ack; a request is never withdrawn.
  - On fetch_ack: head[qid] advances (head==size ? 0 : head+1); outstanding increments; rr_ptr = (qid==C_SQ_NUM-1) ? 0 : qid+1; fetch_req drops next cycle; return to S_IDLE.
  - The earliest next request is 2 cycles after the ack.
- Wrap: head equal to size wraps to 0. Tail values above size are not checked; head simply chases tail through the wrap.
- fetch_done:
  - Decrements outstanding.
  - fetch_ack and fetch_done in the same cycle leave outstanding unchanged.
  - fetch_done with outstanding==0 is ignored and flagged by a simulation-only assertion.
- sq_rst_n[i] low forces head[i] to 0 that cycle and masks pending[i].
- Queue reset while queue i has an outstanding S_REQ: the request completes normally; on ack the head increment for i is suppressed (head stays 0) and outstanding still increments.
- sq_valid dropping during S_REQ has no effect on the active request.
- Full credit: with outstanding==C_MAX_OUTSTANDING, the FSM stays in S_IDLE and heads do not move.
- Asynchronous reset mid-request clears everything immediately; fetch_req drops without ack.

Optional Feature:
- Macro NVME_SQ_ADMIN_PRIO_EN.
- Defined: a pending admin queue (0) always wins over rr_ptr, giving strict priority. rr_ptr updates only on I/O queue grants.
- Undefined: pure round-robin across all queues, admin included.

Decomposition:
- Shared package nvme_sched_pkg holds:
  - state encodings S_IDLE/S_REQ
  - C_SQ_NUM default
  - width constants for qid and pointers
  - the ptr_inc(ptr,size) wrap function
- One sub-module, nvme_rr_arbiter: combinational rotating-priority pick. Inputs are the request vector and rr_ptr; outputs are grant index and any-valid. It can be reused for the CQ side.

Test Plan:
- Reset, then SQ0 valid, size=3, tail=2; ack every request immediately -> two requests (qid0, slot0) and (qid0, slot1); head0=2; outstanding=2.
- Queues 1, 3 and 5 pending, rr_ptr=0; ack every request immediately -> grant order 1,3,5, then back to 1 if it is still pending.
- SQ2 size=3, head=3, tail=1 -> slots 3 then 0 fetched; head2=1.
- C_MAX_OUTSTANDING=4, queue has 6 pending, no fetch_done -> exactly 4 requests, then idle. One fetch_done -> a 5th request. Simultaneous ack+done -> outstanding is unchanged.
- During S_REQ for qid4, pulse sq_rst_n[4] low, then ack -> head4=0; fetch_req was held stable; outstanding increments.
- With NVME_SQ_ADMIN_PRIO_EN defined, SQ0 and SQ6 pending, rr_ptr=6 -> qid0 granted first, then qid6.
